uart_msg_fmt: RTL and testbench
===============================

# uart_msg_fmt

Parametrised successor to the single-word UART hex reporter. It converts queued (channel, data) report requests into ASCII lines of the form "R<ch>:<hex digits>\n\r" and writes them one byte per cycle into the downstream TX byte FIFO that feeds the UART core. Compared with the previous block it adds configurable data width, a channel tag and a request queue, so strobes arriving while a line is in flight are buffered instead of lost.

## Interface
- DW, 16, data width in bits; multiple of 4, range 4..64
- CHW, 3, channel index width; range 1..4
- QDEPTH, 4, request queue depth; power of 2, at least 2
- clk  input  1  single clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- i_tx_data  input  DW  report value
- i_tx_chan  input  CHW  report channel
- i_tx_stb  input  1  push request; accepted only when o_tx_ready=1
- o_tx_ready  output  1  request queue not full
- o_tx_busy  output  1  queue non-empty or state != IDLE
- o_drop  output  1  one-cycle pulse: i_tx_stb while o_tx_ready=0
- o_wr_data  output  8  ASCII byte to TX FIFO
- o_wr_en  output  1  write strobe to TX FIFO
- i_wr_full  input  1  TX FIFO full

## Operation
- Request queue: QDEPTH entries of {chan, data}; push on i_tx_stb & o_tx_ready; pop in IDLE when non-empty. Push and pop in the same cycle are both performed and the count is unchanged. A push while full is discarded and o_drop pulses.
- FSM states: IDLE, R, CH, COL, NIB, NL, CR.
  - IDLE: if queue non-empty, pop the head into the shift register and channel register, load the nibble counter with DW/4-1, and go to R.
  - R, CH, COL, NL: emit "R", the channel char, ":" and 0x0A respectively. Advance only in a cycle where i_wr_full=0.
  - NIB: emit the hex char (uppercase "0"-"9", "A"-"F") of the top nibble. On advance, shift left by 4 and decrement the counter. Leave NIB when the counter is 0.
  - CR: emit 0x0D, then return to IDLE.
- Channel char is the hex char of the zero-extended i_tx_chan.
- o_wr_en = ~i_wr_full & (state is an emitting state). While i_wr_full=1, o_wr_data holds the current byte and the state holds; no byte is duplicated or skipped.
- Line length is DW/4+5 bytes (9 for DW=16).
- Reset: state=IDLE, queue emptied, pending line abandoned. No further bytes of that line are written after the reset cycle.

## Timing
- Reset values: o_wr_en=0, o_wr_data=0x00, o_tx_busy=0, o_tx_ready=1, o_drop=0.
- Strobe accepted in cycle N with the block idle and the queue empty:
  - queue non-empty in N+1, pop at the edge ending N+1;
  - "R" presented with o_wr_en=1 in N+2;
  - with no backpressure, the last byte (0x0D) is presented in N+2+DW/4+4.
- Back-to-back lines: after CR is accepted the FSM spends one IDLE cycle for the pop, so there is one cycle gap between lines.
- o_tx_ready is combinational from the queue count of the current cycle. o_drop is registered and asserted in the cycle after the rejected strobe.

## Configuration
- UART_FMT_ZSUP_EN defined: leading-zero suppression.
  - In NIB, a zero nibble before the first non-zero nibble, other than the last nibble, takes one cycle with o_wr_en=0. It still shifts and decrements, and still stalls while i_wr_full=1.
  - At least one digit is always emitted.
- UART_FMT_ZSUP_EN undefined: all DW/4 digits are always emitted.

## Test plan
Directed scenarios; the parameters are DW=16, CHW=3, QDEPTH=4 unless a scenario states otherwise.
- Basic line, macro undefined: chan=5, data=0x0A3F, strobe at cycle 0 -> bytes 52 35 3A 30 41 33 46 0A 0D on cycles 2..10, o_wr_en high on each, o_tx_busy low from cycle 11.
- Zero suppression, macro defined: data=0x0A3F -> "R5:A3F\n\r"; data=0x0000 -> "R5:0\n\r" (52 35 3A 30 0A 0D).
- Backpressure: i_wr_full=1 for 3 cycles while ":" is presented -> o_wr_en=0 and o_wr_data=0x3A held for 3 cycles, then ":" written exactly once and the line completes unchanged.
- Queue overflow:
  - stimulus: strobes on 6 consecutive cycles starting idle, data 1..6, i_wr_full=0;
  - response: strobes 1-5 accepted; strobe 6 sees o_tx_ready=0, o_drop pulses the next cycle;
  - response: exactly 5 lines are emitted in order 0001..0005, each separated by one idle cycle.
- Reset mid-line: assert rst for one cycle while NIB is emitting, with 2 requests queued -> o_wr_en=0 from that cycle onward, no further bytes, o_tx_busy=0 and o_tx_ready=1 after reset.
- Width corner: DW=4, CHW=4, chan=0xF, data=0x0 -> "RF:0\n\r".

Source files
------------

// File: rtl/uart_msg_fmt.sv
// uart_msg_fmt: turns queued (channel, data) report requests into ASCII
// lines "R<ch>:<hex digits>\n\r" and writes them one byte per cycle into
// the downstream TX byte FIFO.
//
// Parameters: DW (data width, multiple of 4), CHW (channel width, 1..4),
//             QDEPTH (request queue depth, power of 2, >= 2).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_tx_data/chan    report value and channel
//   i_tx_stb          push request (taken only while o_tx_ready=1)
//   o_tx_ready        request queue not full (combinational)
//   o_tx_busy         queue non-empty or a line in flight
//   o_drop            one-cycle pulse after a strobe that found the queue full
//   o_wr_data/o_wr_en ASCII byte and write strobe to the TX FIFO
//   i_wr_full         TX FIFO full; holds the current byte
// Build option: define UART_FMT_ZSUP_EN for leading-zero suppression.
module uart_msg_fmt #(
    parameter int unsigned DW     = 16,
    parameter int unsigned CHW    = 3,
    parameter int unsigned QDEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  i_tx_data,
    input  logic [CHW-1:0] i_tx_chan,
    input  logic           i_tx_stb,
    output logic           o_tx_ready,
    output logic           o_tx_busy,
    output logic           o_drop,
    output logic [7:0]     o_wr_data,
    output logic           o_wr_en,
    input  logic           i_wr_full
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned NW = DW / 4;
    localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned EW = CHW + DW;
    localparam logic [AW:0] QFULL = (AW+1)'(QDEPTH);

    typedef enum logic [2:0] {S_IDLE, S_R, S_CH, S_COL, S_NIB, S_NL, S_CR} state_t;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'(8'h30 + 8'(n)) : 8'(8'h37 + 8'(n));
    endfunction

    // Request queue
    logic [EW-1:0] q_mem [QDEPTH];
    logic [AW-1:0] q_wr, q_rd;
    logic [AW:0]   q_cnt;
    logic          push, pop;
    logic [EW-1:0] head;

    // Line formatter state
    state_t          state_q, state_d;
    logic [DW-1:0]   sh_q, sh_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            emit;
    logic [7:0]      byte_c;
    logic [3:0]      nib;
    logic            drop_q;
`ifdef UART_FMT_ZSUP_EN
    logic            seen_q, seen_d;
`endif

    assign o_tx_ready = (q_cnt != QFULL);
    assign push       = i_tx_stb & o_tx_ready;
    assign pop        = (state_q == S_IDLE) && (q_cnt != '0);
    assign head       = q_mem[q_rd];
    assign nib        = sh_q[DW-1 -: 4];

    // Outputs are forced quiet during the reset cycle so an abandoned line stops at once
    assign o_wr_en   = emit & ~i_wr_full & ~rst;
    assign o_wr_data = rst ? 8'h00 : byte_c;
    assign o_tx_busy = ~rst & ((q_cnt != '0) | (state_q != S_IDLE));
    assign o_drop    = drop_q;

    // Queue storage (no reset needed; validity tracked by q_cnt)
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[q_wr] <= {i_tx_chan, i_tx_data};
        end
    end

    // Queue pointers, count and drop pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            q_wr   <= '0;
            q_rd   <= '0;
            q_cnt  <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= i_tx_stb & ~o_tx_ready;
            if (push) q_wr <= q_wr + AW'(1);
            if (pop)  q_rd <= q_rd + AW'(1);
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + (AW+1)'(1);
                2'b01:   q_cnt <= q_cnt - (AW+1)'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    // FSM state and line datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            ch_q    <= '0;
            cnt_q   <= '0;
`ifdef UART_FMT_ZSUP_EN
            seen_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
`ifdef UART_FMT_ZSUP_EN
            seen_q  <= seen_d;
`endif
        end
    end

    // Next-state, datapath update and byte selection
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
`ifdef UART_FMT_ZSUP_EN
        seen_d  = seen_q;
`endif
        emit    = 1'b0;
        byte_c  = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    sh_d    = head[DW-1:0];
                    ch_d    = head[EW-1:DW];
                    cnt_d   = CW'(NW - 1);
`ifdef UART_FMT_ZSUP_EN
                    seen_d  = 1'b0;
`endif
                    state_d = S_R;
                end
            end
            S_R: begin
                emit   = 1'b1;
                byte_c = 8'h52;
                if (!i_wr_full) state_d = S_CH;
            end
            S_CH: begin
                emit   = 1'b1;
                byte_c = hex_char(4'(ch_q));
                if (!i_wr_full) state_d = S_COL;
            end
            S_COL: begin
                emit   = 1'b1;
                byte_c = 8'h3A;
                if (!i_wr_full) state_d = S_NIB;
            end
            S_NIB: begin
                emit   = 1'b1;
                byte_c = hex_char(nib);
`ifdef UART_FMT_ZSUP_EN
                // Leading zero other than the final digit: silent cycle
                if (!seen_q && (nib == 4'h0) && (cnt_q != '0)) emit = 1'b0;
`endif
                if (!i_wr_full) begin
                    sh_d  = sh_q << 4;
                    cnt_d = cnt_q - CW'(1);
`ifdef UART_FMT_ZSUP_EN
                    if (nib != 4'h0) seen_d = 1'b1;
`endif
                    if (cnt_q == '0) state_d = S_NL;
                end
            end
            S_NL: begin
                emit   = 1'b1;
                byte_c = 8'h0A;
                if (!i_wr_full) state_d = S_CR;
            end
            S_CR: begin
                emit   = 1'b1;
                byte_c = 8'h0D;
                if (!i_wr_full) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_msg_fmt.sv
// Testbench for uart_msg_fmt: directed scenarios plus randomized bursts,
// checked against a line-level reference model (string building per request).
module tb_uart_msg_fmt;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_tx_data;
    logic [2:0]  i_tx_chan;
    logic        i_tx_stb;
    logic        o_tx_ready, o_tx_busy, o_drop, o_wr_en;
    logic [7:0]  o_wr_data;
    logic        i_wr_full;

    // Narrow-width instance
    logic [3:0]  d2, c2;
    logic        stb2, full2;
    logic        rdy2, busy2, drop2, en2;
    logic [7:0]  wd2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    string       hexs = "0123456789ABCDEF";
    logic [7:0]  sch_b[$];
    bit          sch_e[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got[$];
    int          got_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_msg_fmt #(.DW(16), .CHW(3), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst), .i_tx_data(i_tx_data), .i_tx_chan(i_tx_chan),
        .i_tx_stb(i_tx_stb), .o_tx_ready(o_tx_ready), .o_tx_busy(o_tx_busy),
        .o_drop(o_drop), .o_wr_data(o_wr_data), .o_wr_en(o_wr_en),
        .i_wr_full(i_wr_full)
    );

    uart_msg_fmt #(.DW(4), .CHW(4), .QDEPTH(4)) dut_w (
        .clk(clk), .rst(rst), .i_tx_data(d2), .i_tx_chan(c2),
        .i_tx_stb(stb2), .o_tx_ready(rdy2), .o_tx_busy(busy2),
        .o_drop(drop2), .o_wr_data(wd2), .o_wr_en(en2),
        .i_wr_full(full2)
    );

    // Byte monitor for the main instance
    always @(negedge clk) begin
        if (o_wr_en === 1'b1) begin
            got.push_back(o_wr_data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Reference: per-cycle schedule of one line with no backpressure
    task automatic build_sched(input logic [3:0] ch, input logic [15:0] d);
        bit         lead;
        logic [3:0] n;
        sch_b.delete();
        sch_e.delete();
        sch_b.push_back(8'h52);          sch_e.push_back(1'b1);
        sch_b.push_back(8'(hexs[ch]));   sch_e.push_back(1'b1);
        sch_b.push_back(8'h3A);          sch_e.push_back(1'b1);
        lead = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            n = 4'((d >> (4 * i)) & 16'hF);
            if (n != 4'h0) lead = 1'b0;
            sch_b.push_back(8'(hexs[n]));
`ifdef UART_FMT_ZSUP_EN
            sch_e.push_back(!(lead && i != 0));
`else
            sch_e.push_back(1'b1);
`endif
        end
        sch_b.push_back(8'h0A);          sch_e.push_back(1'b1);
        sch_b.push_back(8'h0D);          sch_e.push_back(1'b1);
    endtask

    task automatic append_exp();
        foreach (sch_b[i]) if (sch_e[i]) exp_q.push_back(sch_b[i]);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, " count"}, 64'(got.size()), 64'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, " byte"}, 64'(got[i]), 64'(exp_q[i]));
    endtask

    task automatic clear_mon();
        got.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag, input bit rnd_full);
        int n = 0;
        smp();
        while (o_tx_busy === 1'b1 && n < 1000) begin
            nxt();
            i_wr_full = rnd_full ? 1'($urandom_range(0, 1)) : 1'b0;
            smp();
            n++;
        end
        check({tag, " idle"}, 64'(o_tx_busy), 64'(0));
        nxt();
        i_wr_full = 1'b0;
    endtask

    // One request from idle, cycle-exact, with an optional full window
    task automatic run_line(input logic [2:0] ch, input logic [15:0] d,
                            input int bp_start, input int bp_len, input string tag);
        int idx;
        int t;
        bit full;
        clear_mon();
        build_sched(4'(ch), d);
        append_exp();
        i_tx_chan = ch; i_tx_data = d; i_tx_stb = 1'b1; i_wr_full = 1'b0;
        smp();
        check({tag, " ready"}, 64'(o_tx_ready), 64'(1));
        nxt();
        i_tx_stb = 1'b0;
        smp();
        check({tag, " busy c1"}, 64'(o_tx_busy), 64'(1));
        check({tag, " en c1"}, 64'(o_wr_en), 64'(0));
        idx = 0;
        t = 2;
        while (idx < sch_b.size()) begin
            nxt();
            full = (t >= bp_start) && (t < bp_start + bp_len);
            i_wr_full = full;
            smp();
            check({tag, " en"}, 64'(o_wr_en), 64'(sch_e[idx] & ~full));
            if (sch_e[idx]) check({tag, " data"}, 64'(o_wr_data), 64'(sch_b[idx]));
            if (!full) idx++;
            t++;
        end
        nxt();
        i_wr_full = 1'b0;
        smp();
        check({tag, " busy end"}, 64'(o_tx_busy), 64'(0));
        check({tag, " en end"}, 64'(o_wr_en), 64'(0));
        compare_stream(tag);
        nxt();
    endtask

    initial begin
        int          s0;
        int          lens[$];
        int          nem[$];
        int          pos;
        int          exp_start;
        int          nb;
        logic [15:0] rd;
        logic [7:0]  w_exp [6];

        rst = 1'b1; i_tx_data = '0; i_tx_chan = '0; i_tx_stb = 1'b0; i_wr_full = 1'b0;
        d2 = '0; c2 = '0; stb2 = 1'b0; full2 = 1'b0;
        nxt(); nxt();
        smp();
        check("rst wr_en", 64'(o_wr_en), 64'(0));
        check("rst wr_data", 64'(o_wr_data), 64'(0));
        check("rst busy", 64'(o_tx_busy), 64'(0));
        check("rst ready", 64'(o_tx_ready), 64'(1));
        check("rst drop", 64'(o_drop), 64'(0));
        nxt();
        rst = 1'b0;
        nxt();

        // Basic line, then leading-zero cases, then backpressure on ':'
        run_line(3'd5, 16'h0A3F, -1, 0, "basic");
        run_line(3'd5, 16'h0000, -1, 0, "zero");
        run_line(3'd2, 16'h00F0, -1, 0, "lead0");
        run_line(3'd7, 16'hBEEF, 4, 3, "bp colon");

        // Queue overflow: six back-to-back strobes
        clear_mon();
        lens.delete(); nem.delete();
        s0 = 0;
        for (int k = 1; k <= 6; k++) begin
            i_tx_stb = 1'b1;
            i_tx_data = 16'(k);
            i_tx_chan = 3'($urandom_range(0, 7));
            if (k <= 5) begin
                build_sched(4'(i_tx_chan), i_tx_data);
                append_exp();
                lens.push_back(sch_b.size());
                nb = 0;
                foreach (sch_e[i]) nb += int'(sch_e[i]);
                nem.push_back(nb);
            end
            smp();
            if (k == 1) s0 = cyc;
            check("ovf ready", 64'(o_tx_ready), 64'(k <= 5));
            check("ovf drop early", 64'(o_drop), 64'(0));
            nxt();
        end
        i_tx_stb = 1'b0;
        smp();
        check("ovf drop pulse", 64'(o_drop), 64'(1));
        nxt();
        smp();
        check("ovf drop clear", 64'(o_drop), 64'(0));
        nxt();
        wait_idle("ovf", 1'b0);
        compare_stream("ovf");
        pos = 0;
        exp_start = s0 + 2;
        for (int k = 0; k < 5; k++) begin
            if (pos < got_cyc.size()) check("ovf line start", 64'(got_cyc[pos]), 64'(exp_start));
            exp_start = exp_start + lens[k] + 1;
            pos += nem[k];
        end

        // Reset in the middle of a line with two more requests queued
        for (int k = 0; k < 3; k++) begin
            i_tx_stb = 1'b1;
            i_tx_chan = 3'(k + 1);
            i_tx_data = (k == 0) ? 16'h8123 : 16'(16'h4444 + k);
            smp();
            nxt();
        end
        i_tx_stb = 1'b0;
        nxt(); nxt();
        smp();
        check("midrst nib en", 64'(o_wr_en), 64'(1));
        check("midrst nib data", 64'(o_wr_data), 64'(8'h38));
        nxt();
        rst = 1'b1;
        smp();
        check("midrst en in rst", 64'(o_wr_en), 64'(0));
        nxt();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            smp();
            check("midrst en", 64'(o_wr_en), 64'(0));
            check("midrst busy", 64'(o_tx_busy), 64'(0));
            check("midrst ready", 64'(o_tx_ready), 64'(1));
            nxt();
        end

        // Randomized bursts of at most QDEPTH strobes with random backpressure
        clear_mon();
        for (int b = 0; b < 10; b++) begin
            int n;
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) begin
                rd = 16'($urandom) >> $urandom_range(0, 15);
                i_tx_stb = 1'b1;
                i_tx_data = rd;
                i_tx_chan = 3'($urandom_range(0, 7));
                i_wr_full = 1'($urandom_range(0, 1));
                build_sched(4'(i_tx_chan), rd);
                append_exp();
                smp();
                check("rnd ready", 64'(o_tx_ready), 64'(1));
                check("rnd drop", 64'(o_drop), 64'(0));
                nxt();
                i_tx_stb = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    i_wr_full = 1'($urandom_range(0, 1));
                    nxt();
                end
            end
            i_tx_stb = 1'b0;
            wait_idle("rnd", 1'b1);
        end
        nxt(); nxt();
        compare_stream("rnd");

        // Width corner: DW=4, CHW=4, chan F, data 0
        w_exp = '{8'h52, 8'h46, 8'h3A, 8'h30, 8'h0A, 8'h0D};
        c2 = 4'hF; d2 = 4'h0; stb2 = 1'b1;
        smp();
        nxt();
        stb2 = 1'b0;
        smp();
        for (int i = 0; i < 6; i++) begin
            nxt();
            smp();
            check("w4 en", 64'(en2), 64'(1));
            check("w4 data", 64'(wd2), 64'(w_exp[i]));
        end
        nxt();
        smp();
        check("w4 busy end", 64'(busy2), 64'(0));
        check("w4 en end", 64'(en2), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
